// File: rtl/nios2_oci_arb_pkg.sv
// Shared types for the OCI debug-RAM arbiter.
//   arb_state_t : sequencing FSM states (IDLE -> ISSUE -> [WAIT] -> RESP)
//   owner_t     : which requester owns the operation in flight
//   LAT_CNT_W   : width of the read-latency down-counter (RAM_LAT up to 3)
package nios2_oci_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_JTAG = 1'b0,
        OWN_AVS  = 1'b1
    } owner_t;

    localparam int LAT_CNT_W = 2;

endpackage

// File: rtl/nios2_oci_mem_arbiter.sv
// Round-robin arbiter sharing the single-port OCI debug RAM between the
// JTAG ocimem path and the CPU's Avalon-MM debug slave.
//
// Ports
//   clk, reset                    : clock, asynchronous active-high reset
//   jtag_req/wr/addr/wdata        : single-cycle JTAG request, captured into a
//                                   one-deep holding register
//   jtag_busy, jtag_drop          : holding register occupied / request ignored
//   MonDReg, monitor_ready        : last JTAG read data / no JTAG op outstanding
//   avs_*                         : Avalon-MM slave (waitrequest-stalled)
//   ram_addr/rd/wr/wdata/rdata    : RAM side; read data valid RAM_LAT cycles
//                                   after ram_rd
//   grant_jtag                    : current or most recent grant went to JTAG
module nios2_oci_mem_arbiter
    import nios2_oci_arb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jtag_req,
    input  logic              jtag_wr,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic [DATA_W-1:0] jtag_wdata,
    output logic              jtag_busy,
    output logic              jtag_drop,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              grant_jtag
);

    arb_state_t             state_reg;
    owner_t                 owner_reg;
    owner_t                 last_grant_reg;
    logic                   op_wr_reg;
    logic [LAT_CNT_W-1:0]   cnt_reg;
    logic [DATA_W-1:0]      rd_reg;

    // JTAG holding register
    logic                   pending_reg;
    logic                   p_wr_reg;
    logic [ADDR_W-1:0]      p_addr_reg;
    logic [DATA_W-1:0]      p_wdata_reg;

    logic                   jtag_take;
    logic                   jtag_active;
    logic                   avs_active;
    logic                   pick_jtag;
    logic                   j_wr;
    logic [ADDR_W-1:0]      j_addr;
    logic [DATA_W-1:0]      j_wdata;
    logic                   sel_wr;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_wdata;
    logic                   resp_jtag;
    logic                   pending_next;

    // A fresh jtag_req is arbitrated in the same cycle it is captured, so an
    // idle arbiter starts a JTAG op without waiting a cycle for the holding
    // register; the request fields come straight from the inputs in that case.
    assign jtag_take   = jtag_req & ~pending_reg;
    assign jtag_active = pending_reg | jtag_take;
    assign avs_active  = avs_read | avs_write;
    assign pick_jtag   = jtag_active & (~avs_active | (last_grant_reg == OWN_AVS));

    assign j_wr    = pending_reg ? p_wr_reg    : jtag_wr;
    assign j_addr  = pending_reg ? p_addr_reg  : jtag_addr;
    assign j_wdata = pending_reg ? p_wdata_reg : jtag_wdata;

    // read+write together from the Avalon side is treated as a write
    assign sel_wr    = pick_jtag ? j_wr    : avs_write;
    assign sel_addr  = pick_jtag ? j_addr  : avs_address;
    assign sel_wdata = pick_jtag ? j_wdata : avs_writedata;

    // pending drops at the end of the JTAG RESP cycle; a request arriving in
    // that cycle still sees pending=1 and is dropped
    assign resp_jtag    = (state_reg == RESP) && (owner_reg == OWN_JTAG);
    assign pending_next = resp_jtag ? 1'b0 : (jtag_take ? 1'b1 : pending_reg);

    assign jtag_busy = pending_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            owner_reg       <= OWN_AVS;
            last_grant_reg  <= OWN_AVS;
            op_wr_reg       <= 1'b0;
            cnt_reg         <= '0;
            rd_reg          <= '0;
            pending_reg     <= 1'b0;
            p_wr_reg        <= 1'b0;
            p_addr_reg      <= '0;
            p_wdata_reg     <= '0;
            jtag_drop       <= 1'b0;
            MonDReg         <= '0;
            monitor_ready   <= 1'b1;
            avs_readdata    <= '0;
            avs_waitrequest <= 1'b1;
            ram_addr        <= '0;
            ram_rd          <= 1'b0;
            ram_wr          <= 1'b0;
            ram_wdata       <= '0;
            grant_jtag      <= 1'b0;
        end else begin
            pending_reg   <= pending_next;
            monitor_ready <= ~pending_next;
            jtag_drop     <= jtag_req & pending_reg;
            if (jtag_take) begin
                p_wr_reg    <= jtag_wr;
                p_addr_reg  <= jtag_addr;
                p_wdata_reg <= jtag_wdata;
            end

            // strobes and the Avalon completion are single-cycle by default
            ram_rd          <= 1'b0;
            ram_wr          <= 1'b0;
            avs_waitrequest <= 1'b1;

            case (state_reg)
                IDLE: begin
                    if (jtag_active || avs_active) begin
                        owner_reg      <= pick_jtag ? OWN_JTAG : OWN_AVS;
                        last_grant_reg <= pick_jtag ? OWN_JTAG : OWN_AVS;
                        grant_jtag     <= pick_jtag;
                        op_wr_reg      <= sel_wr;
                        ram_addr       <= sel_addr;
                        if (sel_wr) begin
                            ram_wdata <= sel_wdata;
                            ram_wr    <= 1'b1;
                        end else begin
                            ram_rd    <= 1'b1;
                        end
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (op_wr_reg) begin
                        avs_waitrequest <= (owner_reg != OWN_AVS);
                        state_reg       <= RESP;
                    end else begin
                        cnt_reg   <= LAT_CNT_W'(RAM_LAT);
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - LAT_CNT_W'(1);
                    if (cnt_reg == LAT_CNT_W'(1)) begin
                        rd_reg <= ram_rdata;
                        // Avalon data must be on the bus during RESP itself
                        if (owner_reg == OWN_AVS) begin
                            avs_readdata    <= ram_rdata;
                            avs_waitrequest <= 1'b0;
                        end
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if ((owner_reg == OWN_JTAG) && !op_wr_reg) begin
                        MonDReg <= rd_reg;
                    end
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/nios2_oci_mem_arbiter.md
Name: nios2_oci_mem_arbiter

Overview:
Shares the single-port on-chip-instrumentation (OCI) debug RAM between two requesters.
- JTAG requester: ocimem actions decoded in the sysclk domain by the debug-module sysclk block.
- Avalon-MM requester: the CPU's debug slave port.
- Sequencing: round-robin grant, RAM strobes, read-latency wait, then completion back to each side (monitor_ready/MonDReg for JTAG, waitrequest/readdata for Avalon).
- Placement: between the jtag_debug_module sysclk block and the OCI RAM.

Parameters:
ADDR_W, 8, RAM word-address width
DATA_W, 32, data width
RAM_LAT, 1, RAM read latency in cycles (legal 1..3)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
jtag_req  in  1  single-cycle request pulse (take_action_ocimem_b)
jtag_wr  in  1  1=write, 0=read; qualified by jtag_req
jtag_addr  in  ADDR_W  JTAG address; qualified by jtag_req
jtag_wdata  in  DATA_W  JTAG write data; qualified by jtag_req
jtag_busy  out  1  JTAG holding register occupied
jtag_drop  out  1  one-cycle pulse: jtag_req arrived while busy and was ignored
MonDReg  out  DATA_W  last JTAG read data
monitor_ready  out  1  no JTAG operation outstanding
avs_address  in  ADDR_W  Avalon address
avs_read  in  1  Avalon read
avs_write  in  1  Avalon write
avs_writedata  in  DATA_W  Avalon write data
avs_readdata  out  DATA_W  Avalon read data; valid when waitrequest=0 on a read
avs_waitrequest  out  1  Avalon stall
ram_addr  out  ADDR_W  RAM address
ram_rd  out  1  RAM read strobe
ram_wr  out  1  RAM write strobe
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data; valid RAM_LAT cycles after ram_rd
grant_jtag  out  1  current or most recent grant went to JTAG (debug visibility)

Behaviour:
- Reset values, taken asynchronously on reset:
  - state=IDLE, pending=0, last_grant=AVS so JTAG wins the first tie.
  - jtag_busy=0, jtag_drop=0, MonDReg=0, monitor_ready=1.
  - avs_readdata=0, avs_waitrequest=1.
  - ram_rd=0, ram_wr=0, ram_addr=0, ram_wdata=0, grant_jtag=0.
- JTAG holding register:
  - jtag_req with pending=0: capture wr/addr/wdata, set pending, clear monitor_ready next cycle.
  - jtag_req with pending=1: ignore it and pulse jtag_drop the next cycle.
  - pending clears at the end of that operation's RESP cycle. A jtag_req during the JTAG RESP cycle is dropped.
  - jtag_busy equals pending.
- Avalon request: avs_read|avs_write sampled in IDLE. If both are set, treat as a write.
- avs_waitrequest = NOT(state==RESP AND owner==AVS). It is therefore 1 whenever no Avalon completion is occurring. Masters hold request signals stable per Avalon rules.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE:
    - If only one requester is active, grant it.
    - If both are active, grant the one that is not last_grant.
    - Latch owner, update last_grant and grant_jtag, go to ISSUE.
    - With no requester, stay in IDLE.
  - ISSUE (1 cycle): drive ram_addr, and ram_wdata for writes. Assert ram_rd or ram_wr for exactly this cycle.
    - Write: go to RESP.
    - Read: load counter with RAM_LAT, go to WAIT.
  - WAIT: decrement counter each cycle. In the last cycle (counter==1), capture ram_rdata into rd_reg and go to RESP.
  - RESP (1 cycle):
    - Owner AVS: avs_waitrequest=0; avs_readdata=rd_reg for reads.
    - Owner JTAG: reads load MonDReg<=rd_reg; writes leave MonDReg unchanged. monitor_ready rises the next cycle; pending clears.
    - Go to IDLE.
- Latency, with the request visible in IDLE at cycle t:
  - Write: ISSUE at t+1, RESP at t+2.
  - Read: ISSUE at t+1, RESP at t+2+RAM_LAT.
  - Minimum back-to-back spacing: 3 cycles for writes.
- Fairness: with both requesters continuously active, grants strictly alternate.
- RAM strobes are never asserted outside ISSUE.
- Reset mid-operation: operation abandoned, no further strobes, pending lost. The host re-issues after seeing monitor_ready=1.
- ram_addr and ram_wdata hold their last values outside ISSUE.

Decomposition:
- Package nios2_oci_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - owner enum {OWN_JTAG, OWN_AVS};
  - latency-counter width constant (2 bits).
- No sub-module. The holding register, FSM and round-robin bit all live in one module.

Test Plan:
- JTAG write: jtag_req, wr=1, addr=0x12, wdata=0xDEADBEEF.
  -> ram_wr high exactly 1 cycle with addr 0x12 / data 0xDEADBEEF.
  -> monitor_ready low from cycle t+1 and high again at t+3; MonDReg unchanged.
- Avalon read, RAM_LAT=2: avs_read addr 0x05, RAM returns 0xCAFE0001.
  -> waitrequest low exactly once, 4 cycles after the request; readdata=0xCAFE0001.
- Simultaneous JTAG read and Avalon write out of reset.
  -> JTAG is granted first (grant_jtag=1), then Avalon.
  -> Sustained contention alternates J,A,J,A over 8 operations.
- Second jtag_req while pending.
  -> jtag_drop pulses 1 cycle; exactly one ram strobe occurs; MonDReg reflects the first request.
- reset asserted during WAIT.
  -> all outputs return to reset values within the same cycle; no ram_rd/ram_wr; monitor_ready=1.
- Avalon avs_read and avs_write both high, addr 0x3F.
  -> only ram_wr is issued, with avs_writedata.
